// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: rPLL dynamic-divider mode switching with reset sequencing, lock qualification and retry.
// Mode table entry i sits at MODE_TABLE[18i+17:18i] as {IDSEL, FBDSEL, ODSEL}, already in rPLL port encoding.
module pll_mode_ctrl #(
    parameter int             NUM_MODES    = 2,
    parameter logic [143:0]   MODE_TABLE   = 144'h00144,
    parameter int             RST_HOLD     = 16,
    parameter int             LOCK_STABLE  = 1024,
    parameter int             LOCK_TIMEOUT = 270000,
    parameter int             MAX_RETRIES  = 3,
    parameter int             INIT_MODE    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       pll_lock,
    output logic       locked,
    output logic       dom_rst,
    output logic [2:0] cur_mode,
    output logic       fail,
    output logic       bad_req
);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {APPLY, WAIT_LOCK, RUN, FAIL} state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [3:0]    retry_q, retry_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] stb_q, stb_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bad_d;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          pll_reset_q, dom_rst_q, locked_q, fail_q, ready_q, bad_q;
    logic [17:0]   div_q, entry;

    assign lock_s = sync_q[1];
    assign entry  = MODE_TABLE[18*int'(mode_d) +: 18];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        retry_d = retry_q;
        hold_d  = '0;
        stb_d   = '0;
        tmo_d   = '0;
        bad_d   = 1'b0;
        case (state_q)
            APPLY: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(RST_HOLD - 1)) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end
            end
            WAIT_LOCK: begin
                tmo_d = tmo_q + 1'b1;
                stb_d = lock_s ? stb_q + 1'b1 : '0;
                // a completed stable window beats a simultaneous timeout
                if (stb_q == SW'(LOCK_STABLE)) begin
                    state_d = RUN;
                end else if (tmo_d == TW'(LOCK_TIMEOUT)) begin
                    state_d = (retry_q < 4'(MAX_RETRIES)) ? APPLY : FAIL;
                    retry_d = (retry_q < 4'(MAX_RETRIES)) ? retry_q + 1'b1 : retry_q;
                end
                if (state_d != WAIT_LOCK) begin
                    stb_d = '0;
                    tmo_d = '0;
                end
            end
            RUN: begin
                retry_d = '0;
                state_d = lock_s ? RUN : APPLY;
            end
            default: ;
        endcase
        // an accepted request overrides whatever the state machine chose, including lock loss
        if (ready_q && mode_req_valid) begin
            if (int'(mode_req) < NUM_MODES) begin
                mode_d  = mode_req;
                retry_d = '0;
                state_d = APPLY;
                hold_d  = '0;
                stb_d   = '0;
                tmo_d   = '0;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= APPLY;
            mode_q      <= 3'(INIT_MODE);
            retry_q     <= '0;
            hold_q      <= '0;
            stb_q       <= '0;
            tmo_q       <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            dom_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            ready_q     <= 1'b0;
            bad_q       <= 1'b0;
            div_q       <= MODE_TABLE[18*INIT_MODE +: 18];
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            retry_q     <= retry_d;
            hold_q      <= hold_d;
            stb_q       <= stb_d;
            tmo_q       <= tmo_d;
            // LOCK is meaningless while the PLL is held in reset, so the synchroniser is flushed
            sync_q      <= pll_reset_q ? 2'b00 : {sync_q[0], pll_lock};
            pll_reset_q <= (state_d == APPLY) || (state_d == FAIL);
            dom_rst_q   <= state_d != RUN;
            locked_q    <= state_d == RUN;
            fail_q      <= state_d == FAIL;
            ready_q     <= (state_d == RUN) || (state_d == FAIL);
            bad_q       <= bad_d;
            div_q       <= entry;
        end
    end

    assign pll_reset      = pll_reset_q;
    assign dom_rst        = dom_rst_q;
    assign locked         = locked_q;
    assign fail           = fail_q;
    assign mode_req_ready = ready_q;
    assign bad_req        = bad_q;
    assign cur_mode       = mode_q;
    assign {pll_idsel, pll_fbdsel, pll_odsel} = div_q;
endmodule

// File: tb/tb_pll_mode_ctrl.sv
// tb_pll_mode_ctrl: directed checks of reset sequencing, lock qualification, retries, FAIL and mode requests.
module tb_pll_mode_ctrl;
    localparam logic [17:0] E0 = {6'd1, 6'd2, 6'd3};
    localparam logic [17:0] E1 = {6'd4, 6'd5, 6'd6};
    localparam logic [17:0] E2 = {6'd7, 6'd8, 6'd9};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode_req = 3'd0;
    logic       mode_req_valid = 1'b0;
    logic       mode_req_ready;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock = 1'b1;
    logic       locked, dom_rst, fail, bad_req;
    logic [2:0] cur_mode;
    int         n_chk = 0;
    int         n_fail = 0;

    pll_mode_ctrl #(
        .NUM_MODES(3),
        .MODE_TABLE({90'h0, E2, E1, E0}),
        .RST_HOLD(4),
        .LOCK_STABLE(8),
        .LOCK_TIMEOUT(64),
        .MAX_RETRIES(2),
        .INIT_MODE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .pll_lock(pll_lock), .locked(locked), .dom_rst(dom_rst), .cur_mode(cur_mode),
        .fail(fail), .bad_req(bad_req)
    );

    always #5 clk = ~clk;

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the edge that entered APPLY (skip = cycles already spent).
    task automatic run_apply(string tag, int skip);
        tick(3 - skip);
        chk({tag, " rst_hold"}, 32'(pll_reset), 1);
        tick();
        chk({tag, " rst_fall"}, 32'(pll_reset), 0);
        tick(10);
        chk({tag, " not_yet"}, 32'(locked), 0);
        tick();
        chk({tag, " locked"}, 32'(locked), 1);
        chk({tag, " dom_rst"}, 32'(dom_rst), 0);
        chk({tag, " ready"}, 32'(mode_req_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst pll_reset", 32'(pll_reset), 1);
        chk("rst dom_rst", 32'(dom_rst), 1);
        chk("rst locked", 32'(locked), 0);
        chk("rst fail", 32'(fail), 0);
        chk("rst ready", 32'(mode_req_ready), 0);
        chk("rst bad", 32'(bad_req), 0);
        chk("rst cur_mode", 32'(cur_mode), 0);
        chk("rst div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E0));
        rst = 1'b0;
        run_apply("init", 0);
        chk("init div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E0));

        // one-cycle lock glitch
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        chk("glitch +1", 32'(locked), 1);
        tick();
        chk("glitch +2", 32'(locked), 1);
        tick();
        chk("glitch +3 locked", 32'(locked), 0);
        chk("glitch +3 dom_rst", 32'(dom_rst), 1);
        chk("glitch +3 pll_reset", 32'(pll_reset), 1);
        run_apply("relock", 0);

        // valid request to mode 2; a second request while not ready must be ignored
        mode_req = 3'd2;
        mode_req_valid = 1'b1;
        chk("req ready", 32'(mode_req_ready), 1);
        tick();
        chk("req pll_reset", 32'(pll_reset), 1);
        chk("req locked", 32'(locked), 0);
        chk("req dom_rst", 32'(dom_rst), 1);
        chk("req cur_mode", 32'(cur_mode), 2);
        chk("req div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E2));
        chk("req ready0", 32'(mode_req_ready), 0);
        mode_req = 3'd1;
        tick(2);
        chk("busy ready", 32'(mode_req_ready), 0);
        chk("busy cur_mode", 32'(cur_mode), 2);
        mode_req_valid = 1'b0;
        run_apply("mode2", 2);
        chk("mode2 cur_mode", 32'(cur_mode), 2);
        chk("mode2 div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E2));

        // out-of-range request
        mode_req = 3'd5;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        chk("bad pulse", 32'(bad_req), 1);
        chk("bad locked", 32'(locked), 1);
        chk("bad cur_mode", 32'(cur_mode), 2);
        chk("bad div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E2));
        tick();
        chk("bad clear", 32'(bad_req), 0);
        chk("bad still locked", 32'(locked), 1);

        // lock lost for good: three attempts then FAIL
        pll_lock = 1'b0;
        tick(3);
        chk("loss locked", 32'(locked), 0);
        for (int a = 0; a < 3; a++) begin
            tick(3);
            chk("retry hold", 32'(pll_reset), 1);
            tick();
            chk("retry fall", 32'(pll_reset), 0);
            tick(63);
            chk("retry low", 32'(pll_reset), 0);
            chk("retry nofail", 32'(fail), 0);
            tick();
            chk("retry end reset", 32'(pll_reset), 1);
            chk("retry end fail", 32'(fail), a == 2 ? 1 : 0);
        end
        chk("fail ready", 32'(mode_req_ready), 1);
        chk("fail dom_rst", 32'(dom_rst), 1);
        tick(5);
        chk("fail stays", 32'(fail), 1);
        chk("fail reset stays", 32'(pll_reset), 1);

        // leave FAIL via request for mode 1 with lock back
        pll_lock = 1'b1;
        mode_req = 3'd1;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        chk("exit fail", 32'(fail), 0);
        chk("exit cur_mode", 32'(cur_mode), 1);
        chk("exit div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E1));
        run_apply("mode1", 0);

        // rst during WAIT_LOCK returns to INIT_MODE
        mode_req = 3'd2;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        tick(6);
        chk("midwait reset low", 32'(pll_reset), 0);
        rst = 1'b1;
        tick();
        chk("midrst cur_mode", 32'(cur_mode), 0);
        chk("midrst pll_reset", 32'(pll_reset), 1);
        chk("midrst div", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(E0));
        chk("midrst ready", 32'(mode_req_ready), 0);
        rst = 1'b0;
        run_apply("after rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
